// File: rtl/alu_pkg.sv
// Shared ALU control encodings and multiplier sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/response handshake bundle between the EX stage and the multiply sequencer.
interface alu_mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add MUL (low word) that borrows the shared EX ALU and stalls the pipeline while running.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned          WIDTH    = 32,
  parameter int unsigned          CTRL_W   = 4,
  parameter logic [CTRL_W-1:0]    ADD_CODE = ALU_ADD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_mul_sequencer_if.slave      mul_if,
  input  logic                    i_flush,
  input  logic [CTRL_W-1:0]       i_ex_ctrl,
  input  logic [WIDTH-1:0]        i_ex_a,
  input  logic [WIDTH-1:0]        i_ex_b,
  output logic [CTRL_W-1:0]       o_alu_ctrl,
  output logic [WIDTH-1:0]        o_alu_a,
  output logic [WIDTH-1:0]        o_alu_b,
  input  logic [WIDTH-1:0]        i_alu_result,
  output logic                    o_stall
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mul_state_t       r_state, w_state_next;
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && mul_if.in_valid && !i_flush;

`ifdef MUL_EARLY_EXIT_EN
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (r_mplier == '0);
`else
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    w_state_next     = r_state;
    mul_if.in_ready  = 1'b0;
    mul_if.out_valid = 1'b0;
    o_stall          = 1'b0;
    o_alu_ctrl       = i_ex_ctrl;
    o_alu_a          = i_ex_a;
    o_alu_b          = i_ex_b;
    unique case (r_state)
      IDLE: begin
        mul_if.in_ready = 1'b1;
        if (w_accept) w_state_next = RUN;
      end
      RUN: begin
        o_stall    = 1'b1;
        o_alu_ctrl = ADD_CODE;
        o_alu_a    = r_acc;
        o_alu_b    = r_mcand;
        if (i_flush)     w_state_next = IDLE;
        else if (w_last) w_state_next = DONE;
      end
      DONE: begin
        mul_if.out_valid = 1'b1;
        // flush wins over the output handshake; both return to IDLE
        if (i_flush || mul_if.out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign mul_if.out_data = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_acc    <= '0;
        r_mcand  <= mul_if.op_a;
        r_mplier <= mul_if.op_b;
        r_cnt    <= '0;
      end else if (r_state == RUN) begin
        if (r_mplier[0]) r_acc <= i_alu_result;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
